counter_event_monitor: RTL and testbench

- Downstream stage of the n-bit up/down counter with parallel load.
- Watches the counter output Q and the control inputs that drive it.
- Detects wrap-around events, keeps a saturating wrap tally, and raises a compare-match interrupt through a small arm/hold state machine.
- Feeds the interrupt and status logic above the counter.

---
 rtl/counter_event_monitor.sv | 162 ++++++++++++++++
 tb/tb_counter_event_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_event_monitor.sv
// counter_event_monitor
// Sits downstream of an N-bit up/down counter with parallel load. It detects
// counting wrap-arounds (not loads), keeps a saturating wrap tally, and raises
// a sticky compare-match interrupt through an IDLE/ARMED/HOLD state machine.
//
// Optional build feature: define COUNTER_EVENT_MONITOR_MISS_EN to add the
// miss_cnt output, a saturating count of hits that arrive while an interrupt
// is already pending (state HOLD) and the counter has moved.
module counter_event_monitor #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] count_q,
    input  logic         cnt_load,
    input  logic         cnt_up_down_n,
    input  logic         arm,
    input  logic         cmp_wr,
    input  logic [N-1:0] cmp_data,
    input  logic         irq_ack,
    input  logic         wrap_clr,
    output logic         match_pulse,
    output logic         wrap_pulse,
    output logic         irq,
    output logic [W-1:0] wrap_cnt,
    output logic [1:0]   state_o
`ifdef COUNTER_EVENT_MONITOR_MISS_EN
    ,
    output logic [7:0]   miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [N-1:0] ALL_ONES  = {N{1'b1}};
    localparam logic [N-1:0] ALL_ZEROS = {N{1'b0}};
    localparam logic [W-1:0] WRAP_MAX  = {W{1'b1}};

    state_t         state_reg;
    logic [N-1:0]   prev_q_reg;
    logic           prev_load_reg;
    logic           prev_dir_reg;
    logic           prev_valid_reg;
    logic [N-1:0]   cmp_val_reg;

    logic           up_wrap;
    logic           down_wrap;
    logic           wrap_det;
    logic           hit;

    // One-cycle history of the counter output and the controls that produced
    // the current value; prev_valid masks the first cycle after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q_reg     <= ALL_ZEROS;
            prev_load_reg  <= 1'b0;
            prev_dir_reg   <= 1'b0;
            prev_valid_reg <= 1'b0;
        end else begin
            prev_q_reg     <= count_q;
            prev_load_reg  <= cnt_load;
            prev_dir_reg   <= cnt_up_down_n;
            prev_valid_reg <= 1'b1;
        end
    end

    // A wrap is a counting step across the boundary; loads never count.
    assign up_wrap   = prev_dir_reg  && (prev_q_reg == ALL_ONES)  && (count_q == ALL_ZEROS);
    assign down_wrap = !prev_dir_reg && (prev_q_reg == ALL_ZEROS) && (count_q == ALL_ONES);
    assign wrap_det  = prev_valid_reg && !prev_load_reg && (up_wrap || down_wrap);

    assign hit = (count_q == cmp_val_reg);

    // Registered wrap pulse and saturating tally; a clear that coincides with
    // a wrap keeps that wrap, so the tally restarts at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            wrap_pulse <= wrap_det;
            if (wrap_clr) begin
                wrap_cnt <= wrap_det ? W'(1) : '0;
            end else if (wrap_det && (wrap_cnt != WRAP_MAX)) begin
                wrap_cnt <= wrap_cnt + W'(1);
            end
        end
    end

    // Compare value; a write takes effect for matching on the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_val_reg <= ALL_ZEROS;
        end else if (cmp_wr) begin
            cmp_val_reg <= cmp_data;
        end
    end

    // Arm/hold state machine with registered match pulse and sticky irq.
    // In ARMED, dropping arm beats a hit; in HOLD, an ack beats a hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            match_pulse <= 1'b0;
            irq         <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arm) begin
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        state_reg <= IDLE;
                    end else if (hit) begin
                        state_reg   <= HOLD;
                        match_pulse <= 1'b1;
                        irq         <= 1'b1;
                    end
                end
                HOLD: begin
                    if (irq_ack) begin
                        state_reg <= arm ? ARMED : IDLE;
                        irq       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    irq       <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_reg;

`ifdef COUNTER_EVENT_MONITOR_MISS_EN
    logic count_changed;

    assign count_changed = (count_q != prev_q_reg);

    // Hits that land while an interrupt is pending are tallied as misses,
    // but only when the counter has actually moved onto the compare value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt <= 8'd0;
        end else if (wrap_clr) begin
            miss_cnt <= 8'd0;
        end else if ((state_reg == HOLD) && hit && count_changed && (miss_cnt != 8'hFF)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_counter_event_monitor.sv
// Scoreboard bench for counter_event_monitor. A driver emulates the upstream
// counter, issues directed and random controls, and pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_counter_event_monitor;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] count_q;
    logic         cnt_load;
    logic         cnt_up_down_n;
    logic         arm;
    logic         cmp_wr;
    logic [N-1:0] cmp_data;
    logic         irq_ack;
    logic         wrap_clr;
    logic         match_pulse;
    logic         wrap_pulse;
    logic         irq;
    logic [W-1:0] wrap_cnt;
    logic [1:0]   state_o;
    logic [7:0]   miss_act;

    counter_event_monitor #(.N(N), .W(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .count_q       (count_q),
        .cnt_load      (cnt_load),
        .cnt_up_down_n (cnt_up_down_n),
        .arm           (arm),
        .cmp_wr        (cmp_wr),
        .cmp_data      (cmp_data),
        .irq_ack       (irq_ack),
        .wrap_clr      (wrap_clr),
        .match_pulse   (match_pulse),
        .wrap_pulse    (wrap_pulse),
        .irq           (irq),
        .wrap_cnt      (wrap_cnt),
        .state_o       (state_o)
`ifdef COUNTER_EVENT_MONITOR_MISS_EN
        ,
        .miss_cnt      (miss_act)
`endif
    );

`ifndef COUNTER_EVENT_MONITOR_MISS_EN
    assign miss_act = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mp;
        logic       wp;
        logic       irq;
        logic [7:0] wc;
        logic [1:0] st;
        logic [7:0] miss;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Behavioural model state: the counter value driven next, whether the
    // previous step crossed the counting range, and the monitor's view.
    int q;
    bit m_pend;
    int m_last_q;
    int m_state;      // 0 idle, 1 armed, 2 hold
    bit m_irq;
    int m_wc;
    int m_cmp;
    int m_miss;
    bit arm_lvl;

    task automatic model_reset();
        q        = 0;
        m_pend   = 1'b0;
        m_last_q = 0;
        m_state  = 0;
        m_irq    = 1'b0;
        m_wc     = 0;
        m_cmp    = 0;
        m_miss   = 0;
    endtask

    // One counter cycle: drive inputs at the falling edge, predict outputs
    // after the next rising edge, then advance the emulated counter.
    task automatic step(input bit ld, input bit dir, input logic [3:0] d,
                        input bit a, input bit cw, input logic [3:0] cd,
                        input bit ack, input bit clr);
        exp_t e;
        bit   det;
        bit   hit;
        bit   mp;
        int   nq;
        @(negedge clk);
        count_q       = 4'(q);
        cnt_load      = ld;
        cnt_up_down_n = dir;
        arm           = a;
        cmp_wr        = cw;
        cmp_data      = cd;
        irq_ack       = ack;
        wrap_clr      = clr;

        det = m_pend;
        hit = (q == m_cmp);
        mp  = 1'b0;
        if (clr) m_wc = det ? 1 : 0;
        else if (det && m_wc < 255) m_wc = m_wc + 1;
        if (clr) m_miss = 0;
        else if (m_state == 2 && hit && q != m_last_q && m_miss < 255) m_miss = m_miss + 1;
        case (m_state)
            0: if (a) m_state = 1;
            1: begin
                if (!a) m_state = 0;
                else if (hit) begin
                    m_state = 2;
                    mp      = 1'b1;
                    m_irq   = 1'b1;
                end
            end
            default: begin
                if (ack) begin
                    m_state = a ? 1 : 0;
                    m_irq   = 1'b0;
                end
            end
        endcase
        e.mp  = mp;
        e.wp  = det;
        e.irq = m_irq;
        e.wc  = 8'(m_wc);
        e.st  = 2'(m_state);
`ifdef COUNTER_EVENT_MONITOR_MISS_EN
        e.miss = 8'(m_miss);
`else
        e.miss = 8'd0;
`endif
        sb.push_back(e);

        if (cw) m_cmp = int'(cd);
        m_last_q = q;
        if (ld) begin
            nq     = int'(d);
            m_pend = 1'b0;
        end else if (dir) begin
            nq     = q + 1;
            m_pend = (nq > 15);
            nq     = nq % 16;
        end else begin
            nq     = q - 1;
            m_pend = (nq < 0);
            nq     = (nq + 16) % 16;
        end
        q = nq;
    endtask

    task automatic count_steps(input int n, input bit dir);
        for (int i = 0; i < n; i++) step(1'b0, dir, 4'd0, arm_lvl, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic hold_at(input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, v, arm_lvl, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({match_pulse, wrap_pulse, irq, wrap_cnt, state_o, miss_act} != '0) begin
            errors++;
            $display("FAIL %s: got mp=%b wp=%b irq=%b wc=%0d st=%b miss=%0d, required all zero",
                     tag, match_pulse, wrap_pulse, irq, wrap_cnt, state_o, miss_act);
        end
    endtask

    // Monitor: every rising edge that has a pending expectation is checked.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = '{match_pulse, wrap_pulse, irq, wrap_cnt, state_o, miss_act};
                txn++;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL sb#%0d: got mp=%b wp=%b irq=%b wc=%0d st=%b miss=%0d, required mp=%b wp=%b irq=%b wc=%0d st=%b miss=%0d",
                             txn, act.mp, act.wp, act.irq, act.wc, act.st, act.miss,
                             e.mp, e.wp, e.irq, e.wc, e.st, e.miss);
                end else if (e.mp || e.wp) begin
                    $display("txn %0d: event mp=%b wp=%b irq=%b wc=%0d st=%b ok",
                             txn, e.mp, e.wp, e.irq, e.wc, e.st);
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        count_q       = '0;
        cnt_load      = 1'b0;
        cnt_up_down_n = 1'b1;
        arm           = 1'b0;
        cmp_wr        = 1'b0;
        cmp_data      = '0;
        irq_ack       = 1'b0;
        wrap_clr      = 1'b0;
        arm_lvl       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Up count through 15 -> 0: one wrap pulse, tally 1.
        count_steps(19, 1'b1);

        // Load 0 from 15 is not a wrap; then a down step 0 -> 15 is.
        step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        count_steps(4, 1'b0);

        // Compare at 9: match, hold without re-pulse, ack and rematch.
        arm_lvl = 1'b1;
        step(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
        count_steps(9, 1'b1);
        hold_at(4, 4'd9);
        step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        hold_at(3, 4'd9);
        step(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        arm_lvl = 1'b0;
        hold_at(2, 4'd9);

        // 260 up wraps saturate the tally, then clear coinciding with a wrap.
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        count_steps(260 * 16 + 15, 1'b1);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        count_steps(3, 1'b1);

        // In HOLD: ack, hit on a freshly changed count and arm low together.
        step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hold_at(2, 4'd5);

        // Reach HOLD with tally 5, then reset asynchronously mid-cycle.
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        count_steps(5 * 16, 1'b1);
        arm_lvl = 1'b1;
        step(1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        count_steps(3, 1'b1);
        hold_at(2, 4'd15);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset_mid_hold");
        model_reset();
        arm_lvl = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        count_steps(3, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(19) == 0) arm_lvl = ~arm_lvl;
            step($urandom_range(9) == 0, 1'($urandom_range(1)), 4'($urandom_range(15)),
                 arm_lvl, $urandom_range(15) == 0, 4'($urandom_range(15)),
                 $urandom_range(4) == 0, $urandom_range(39) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
